// File: rtl/mem_arbiter.sv
// Two-client block-memory arbiter: I-cache (read) and D-cache (read/write) share one memory port.
// Optional MEM_ARB_FIXED_PRIO_EN: D-cache always wins ties; otherwise round-robin on ties.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              proc_reset_n,
   input  logic              ic_mem_read,
   input  logic [ADDR_W-1:0] ic_mem_addr,
   output logic [DATA_W-1:0] ic_mem_rdata,
   output logic              ic_mem_ready,
   input  logic              dc_mem_read,
   input  logic              dc_mem_write,
   input  logic [ADDR_W-1:0] dc_mem_addr,
   input  logic [DATA_W-1:0] dc_mem_wdata,
   output logic [DATA_W-1:0] dc_mem_rdata,
   output logic              dc_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_e;

   state_e              state_q, state_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                req_i, req_d, pick_d;

   assign req_i = ic_mem_read;
   assign req_d = dc_mem_read | dc_mem_write;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign pick_d = req_d;
`else
   // last_d_q=1 means the previous grant went to the D-cache, so I wins the next tie
   logic last_d_q, last_d_d;
   assign pick_d = req_d & (~req_i | ~last_d_q);

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) last_d_q <= 1'b1;
      else               last_d_q <= last_d_d;
   end

   always_comb begin
      last_d_d = last_d_q;
      if (state_q == IDLE && (req_i || req_d)) last_d_d = pick_d;
   end
`endif

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d     = BUSY_D;
               mem_addr_d  = dc_mem_addr;
               mem_wdata_d = dc_mem_wdata;
               mem_write_d = dc_mem_write;
               mem_read_d  = dc_mem_read & ~dc_mem_write;
            end else if (req_i) begin
               state_d     = BUSY_I;
               mem_addr_d  = ic_mem_addr;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               state_d     = RELEASE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ic_mem_ready = (state_q == BUSY_I) & mem_ready;
      dc_mem_ready = (state_q == BUSY_D) & mem_ready;
   end

   assign mem_read     = mem_read_q;
   assign mem_write    = mem_write_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign ic_mem_rdata = mem_rdata;
   assign dc_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, strobes, ready routing, round-robin, reset abort.
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          proc_reset_n;
   logic          ic_mem_read;
   logic [AW-1:0] ic_mem_addr;
   logic [DW-1:0] ic_mem_rdata;
   logic          ic_mem_ready;
   logic          dc_mem_read, dc_mem_write;
   logic [AW-1:0] dc_mem_addr;
   logic [DW-1:0] dc_mem_wdata, dc_mem_rdata;
   logic          dc_mem_ready;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ready;

   int n_chk  = 0;
   int n_fail = 0;

   mem_arbiter dut (
      .clk(clk), .proc_reset_n(proc_reset_n),
      .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
      .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
      .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
      .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
      .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   localparam logic [AW-1:0] IA = 28'h0000010;
   localparam logic [AW-1:0] DA = 28'h00000A0;
   localparam logic [DW-1:0] WD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
   localparam logic [DW-1:0] RD = 128'h11112222_33334444_55556666_77778888;

   logic exp_d;

   initial begin
      proc_reset_n = 1'b0;
      ic_mem_read = 0; ic_mem_addr = '0;
      dc_mem_read = 0; dc_mem_write = 0; dc_mem_addr = '0; dc_mem_wdata = '0;
      mem_rdata = '0; mem_ready = 0;
      tick(); tick();
      chk("rst_mem_read",  DW'(mem_read), 0);
      chk("rst_mem_write", DW'(mem_write), 0);
      chk("rst_mem_addr",  DW'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_ic_ready",  DW'(ic_mem_ready), 0);
      chk("rst_dc_ready",  DW'(dc_mem_ready), 0);
      proc_reset_n = 1'b1;
      tick();

      // 1: I-cache read
      ic_mem_read = 1; ic_mem_addr = IA;
      tick();
      chk("t1_mem_read",  DW'(mem_read), 1);
      chk("t1_mem_write", DW'(mem_write), 0);
      chk("t1_mem_addr",  DW'(mem_addr), DW'(IA));
      chk("t1_ic_ready_wait", DW'(ic_mem_ready), 0);
      mem_ready = 1; mem_rdata = RD;
      #1;
      chk("t1_ic_ready", DW'(ic_mem_ready), 1);
      chk("t1_dc_ready", DW'(dc_mem_ready), 0);
      chk("t1_ic_rdata", ic_mem_rdata, RD);
      chk("t1_dc_rdata", dc_mem_rdata, RD);
      tick();
      mem_ready = 0; ic_mem_read = 0;
      chk("t1_strobe_low", DW'(mem_read), 0);
      tick();

      // 2: D-cache write-back with simultaneous read flag; write wins
      dc_mem_write = 1; dc_mem_read = 1; dc_mem_addr = DA; dc_mem_wdata = WD;
      tick();
      chk("t2_mem_write", DW'(mem_write), 1);
      chk("t2_mem_read",  DW'(mem_read), 0);
      chk("t2_mem_addr",  DW'(mem_addr), DW'(DA));
      chk("t2_mem_wdata", mem_wdata, WD);
      mem_ready = 1;
      #1;
      chk("t2_dc_ready", DW'(dc_mem_ready), 1);
      chk("t2_ic_ready", DW'(ic_mem_ready), 0);
      tick();
      mem_ready = 0; dc_mem_write = 0; dc_mem_read = 0;
      chk("t2_strobe_low", DW'(mem_write), 0);
      tick();

      // 3: four ties; last grant was D, so round-robin starts with I
      ic_mem_read = 1; ic_mem_addr = IA;
      dc_mem_write = 1; dc_mem_addr = DA;
      for (int r = 0; r < 4; r++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         exp_d = 1'b1;
`else
         exp_d = (r % 2) == 1;
`endif
         tick();
         chk($sformatf("t3_addr_r%0d", r), DW'(mem_addr), exp_d ? DW'(DA) : DW'(IA));
         chk($sformatf("t3_write_r%0d", r), DW'(mem_write), DW'(exp_d));
         mem_ready = 1;
         #1;
         chk($sformatf("t3_ic_ready_r%0d", r), DW'(ic_mem_ready), DW'(!exp_d));
         chk($sformatf("t3_dc_ready_r%0d", r), DW'(dc_mem_ready), DW'(exp_d));
         tick();
         mem_ready = 0;
         tick();
      end
      ic_mem_read = 0; dc_mem_write = 0;
      tick();

      // 4: address change ignored while busy; mem_ready held 3 cycles
      ic_mem_read = 1; ic_mem_addr = IA;
      tick();
      ic_mem_addr = 28'h0ABCDEF;
      tick();
      chk("t4_addr_held", DW'(mem_addr), DW'(IA));
      mem_ready = 1;
      #1;
      chk("t4_ready_c1", DW'(ic_mem_ready), 1);
      tick();
      ic_mem_read = 0;
      chk("t4_ready_c2", DW'(ic_mem_ready), 0);
      chk("t4_release_strobe", DW'(mem_read), 0);
      tick();
      chk("t4_ready_c3", DW'(ic_mem_ready), 0);
      chk("t4_dc_ready_c3", DW'(dc_mem_ready), 0);
      mem_ready = 0;
      ic_mem_read = 1; ic_mem_addr = 28'h0000040;
      tick();
      chk("t4_regrant_read", DW'(mem_read), 1);
      chk("t4_regrant_addr", DW'(mem_addr), 28'h0000040);
      mem_ready = 1;
      tick();
      mem_ready = 0; ic_mem_read = 0;
      tick();

      // 5: reset during D-cache write
      dc_mem_write = 1; dc_mem_addr = DA; dc_mem_wdata = WD;
      tick();
      chk("t5_write_up", DW'(mem_write), 1);
      proc_reset_n = 0;
      #1;
      chk("t5_write_async_low", DW'(mem_write), 0);
      chk("t5_addr_cleared", DW'(mem_addr), 0);
      mem_ready = 1;
      #1;
      chk("t5_no_dc_ready", DW'(dc_mem_ready), 0);
      tick();
      mem_ready = 0; dc_mem_write = 0;
      proc_reset_n = 1;
      tick();
      ic_mem_read = 1; ic_mem_addr = IA;
      tick();
      chk("t5_fresh_read", DW'(mem_read), 1);
      chk("t5_fresh_addr", DW'(mem_addr), DW'(IA));
      mem_ready = 1;
      #1;
      chk("t5_fresh_ic_ready", DW'(ic_mem_ready), 1);
      tick();
      mem_ready = 0; ic_mem_read = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
